// File: rtl/timing_decode_unit.sv
// rtl/timing_decode_unit.sv - sequence counter, instruction register and run/halt front end
// Optional retired-instruction counter enabled by INSTR_COUNT_EN.
module timing_decode_unit #(
  parameter int SC_W = 3,
  parameter int T_N  = 7,
  parameter int IR_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            glb_clr,
  input  logic            seq_clr,
  input  logic            ir_ld,
  input  logic [IR_W-1:0] bus,
  input  logic            err_halt,
  input  logic            start,
  output logic [T_N-1:0]  T,
  output logic [7:0]      D,
  output logic            I,
  output logic [11:0]     B,
  output logic            running,
  output logic            seq_err,
  output logic [SC_W-1:0] sc,
  output logic [15:0]     instr_cnt
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [SC_W-1:0] sc_q, sc_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic            seq_err_q, seq_err_d;
  logic            run;
  logic            hlt_int;
  logic            halt_entry;

  assign run = (state_q == RUN);

  always_comb begin
    for (int k = 0; k < T_N; k++) begin
      T[k] = run && (sc_q == SC_W'(k));
    end
    for (int k = 0; k < 8; k++) begin
      D[k] = (ir_q[14:12] == 3'(k));
    end
  end

  assign I       = ir_q[15];
  assign B       = ir_q[11:0];
  assign running = run;
  assign seq_err = seq_err_q;
  assign sc      = sc_q;

  // Internal HLT is a register-reference instruction (D7, direct) with B0 set, at T3.
  assign hlt_int    = T[3] & D[7] & ~I & B[0];
  assign halt_entry = run & (hlt_int | err_halt);

  always_comb begin
    state_d   = state_q;
    sc_d      = sc_q;
    ir_d      = ir_q;
    seq_err_d = seq_err_q;
    if (glb_clr) begin
      state_d   = RUN;
      sc_d      = '0;
      ir_d      = '0;
      seq_err_d = 1'b0;
    end else if (run) begin
      if (ir_ld) begin
        ir_d = bus;
      end
      if (halt_entry) begin
        state_d = HALT;
        sc_d    = '0;
      end else if (seq_clr) begin
        sc_d = '0;
      end else if (sc_q == SC_W'(T_N - 1)) begin
        sc_d      = '0;
        seq_err_d = 1'b1;
      end else begin
        sc_d = sc_q + SC_W'(1);
      end
    end else if (start) begin
      state_d = RUN;
      sc_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      sc_q      <= '0;
      ir_q      <= '0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sc_q      <= sc_d;
      ir_q      <= ir_d;
      seq_err_q <= seq_err_d;
    end
  end

`ifdef INSTR_COUNT_EN
  logic [15:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    instr_cnt_d = instr_cnt_q;
    if (glb_clr) begin
      instr_cnt_d = '0;
    end else if (seq_clr && run) begin
      instr_cnt_d = instr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_q <= '0;
    end else begin
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign instr_cnt = instr_cnt_q;
`else
  assign instr_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_timing_decode_unit.sv
// tb/tb_timing_decode_unit.sv - directed self-checking bench for timing_decode_unit
module tb_timing_decode_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        glb_clr, seq_clr, ir_ld, err_halt, start;
  logic [15:0] bus;
  logic [6:0]  T;
  logic [7:0]  D;
  logic        I;
  logic [11:0] B;
  logic        running, seq_err;
  logic [2:0]  sc;
  logic [15:0] instr_cnt;

  int checks = 0;
  int fails  = 0;

  timing_decode_unit dut (
    .clk(clk), .rst_n(rst_n), .glb_clr(glb_clr), .seq_clr(seq_clr),
    .ir_ld(ir_ld), .bus(bus), .err_halt(err_halt), .start(start),
    .T(T), .D(D), .I(I), .B(B), .running(running), .seq_err(seq_err),
    .sc(sc), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; glb_clr = 0; seq_clr = 0; ir_ld = 0; err_halt = 0; start = 0; bus = '0;
    #3;
    chk("rst_T", 16'(T), 16'h01);
    chk("rst_D", 16'(D), 16'h01);
    chk("rst_I", 16'(I), 16'h0);
    chk("rst_B", 16'(B), 16'h000);
    chk("rst_running", 16'(running), 16'h1);
    chk("rst_seq_err", 16'(seq_err), 16'h0);
    chk("rst_instr_cnt", instr_cnt, 16'h0000);
    tick();
    rst_n = 1'b1;

    // free run through T0..T6 and overrun
    for (int k = 1; k < 7; k++) begin
      tick();
      chk($sformatf("walk_T%0d", k), 16'(T), 16'(7'b1 << k));
    end
    chk("walk_no_err_T6", 16'(seq_err), 16'h0);
    tick();
    chk("wrap_T", 16'(T), 16'h01);
    chk("wrap_sc", 16'(sc), 16'h0);
    chk("wrap_seq_err", 16'(seq_err), 16'h1);

    // HLT instruction 0x7001
    tick();
    bus = 16'h7001; ir_ld = 1;
    tick();
    ir_ld = 0;
    chk("hlt_T2", 16'(T), 16'h04);
    chk("hlt_D", 16'(D), 16'h80);
    chk("hlt_I", 16'(I), 16'h0);
    chk("hlt_B", 16'(B), 16'h001);
    tick();
    chk("hlt_T3", 16'(T), 16'h08);
    tick();
    chk("hlt_running", 16'(running), 16'h0);
    chk("hlt_T", 16'(T), 16'h00);
    chk("hlt_sc", 16'(sc), 16'h0);
    tick();
    chk("hlt_hold_T", 16'(T), 16'h00);
    start = 1;
    tick();
    start = 0;
    chk("start_running", 16'(running), 16'h1);
    chk("start_T", 16'(T), 16'h01);
    chk("start_seq_err_sticky", 16'(seq_err), 16'h1);

    // instruction 0x2123 finishing with seq_clr at T5
    tick();
    bus = 16'h2123; ir_ld = 1;
    tick();
    ir_ld = 0;
    chk("and_D", 16'(D), 16'h04);
    chk("and_B", 16'(B), 16'h123);
    tick(); tick(); tick();
    chk("and_T5", 16'(T), 16'h20);
    seq_clr = 1;
    tick();
    seq_clr = 0;
    chk("and_T_after_clr", 16'(T), 16'h01);
    chk("and_sc", 16'(sc), 16'h0);
    chk("and_D_hold", 16'(D), 16'h04);
    chk("and_I", 16'(I), 16'h0);
    chk("and_B_hold", 16'(B), 16'h123);
`ifdef INSTR_COUNT_EN
    chk("and_instr_cnt", instr_cnt, 16'h0001);
`else
    chk("and_instr_cnt", instr_cnt, 16'h0000);
`endif

    // err_halt with seq_clr at T2, IR frozen in HALT, glb_clr recovery
    tick(); tick();
    chk("eh_T2", 16'(T), 16'h04);
    err_halt = 1; seq_clr = 1;
    tick();
    err_halt = 0; seq_clr = 0;
    chk("eh_running", 16'(running), 16'h0);
    chk("eh_sc", 16'(sc), 16'h0);
    chk("eh_T", 16'(T), 16'h00);
    bus = 16'hFFFF; ir_ld = 1;
    tick();
    ir_ld = 0;
    chk("eh_ir_frozen_B", 16'(B), 16'h123);
    chk("eh_ir_frozen_D", 16'(D), 16'h04);
    glb_clr = 1;
    tick();
    glb_clr = 0;
    chk("gc_running", 16'(running), 16'h1);
    chk("gc_T", 16'(T), 16'h01);
    chk("gc_B", 16'(B), 16'h000);
    chk("gc_D", 16'(D), 16'h01);
    chk("gc_seq_err", 16'(seq_err), 16'h0);
    chk("gc_instr_cnt", instr_cnt, 16'h0000);

    // start while running is ignored
    start = 1;
    tick();
    start = 0;
    chk("start_in_run_T", 16'(T), 16'h02);

    // IR still loads on the halt-entry edge
    err_halt = 1; ir_ld = 1; bus = 16'h3456;
    tick();
    err_halt = 0; ir_ld = 0;
    chk("ldhalt_running", 16'(running), 16'h0);
    chk("ldhalt_D", 16'(D), 16'h08);
    chk("ldhalt_B", 16'(B), 16'h456);
    start = 1;
    tick();
    start = 0;
    chk("ldhalt_restart_T", 16'(T), 16'h01);

`ifdef INSTR_COUNT_EN
    glb_clr = 1;
    tick();
    glb_clr = 0;
    seq_clr = 1;
    repeat (65535) @(posedge clk);
    #1;
    chk("cnt_ffff", instr_cnt, 16'hFFFF);
    tick();
    seq_clr = 0;
    chk("cnt_wrap", instr_cnt, 16'h0000);
`endif

    // async reset mid-instruction with SC=4, IR=0xF020
    tick();
    bus = 16'hF020; ir_ld = 1;
    tick();
    ir_ld = 0;
    chk("mid_I", 16'(I), 16'h1);
    tick(); tick();
    chk("mid_sc", 16'(sc), 16'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sc", 16'(sc), 16'h0);
    chk("arst_T", 16'(T), 16'h01);
    chk("arst_I", 16'(I), 16'h0);
    chk("arst_B", 16'(B), 16'h000);
    chk("arst_running", 16'(running), 16'h1);
    tick();
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/timing_decode_unit.md
Name: timing_decode_unit

Overview:
Sequencing and instruction-decode front end that directly feeds top_control_unit. It holds the sequence counter (SC), the instruction register (IR) and the run/halt state. It produces the one-hot timing bus T[6:0], the opcode decode D[7:0], the indirect bit I and the register-reference field B[11:0]. It consumes seq_clr, ld[2] (IR load) and glb_clr from the control unit, plus the 16-bit data bus.

Parameters:
SC_W, 3, sequence counter width
T_N, 7, number of timing states (T0..T6)
IR_W, 16, instruction register width

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
glb_clr  input  1  synchronous global clear
seq_clr  input  1  clear SC (end of instruction / interrupt cycle)
ir_ld  input  1  load IR from bus (control unit ld[2])
bus  input  16  common data bus
err_halt  input  1  external halt request (wrong instruction / error register)
start  input  1  single-cycle pulse, leave HALT
T  output  7  one-hot timing signals, all zero when not running
D  output  8  one-hot decode of IR[14:12]
I  output  1  IR[15]
B  output  12  IR[11:0]
running  output  1  high in RUN state
seq_err  output  1  sticky: SC overran T6 without seq_clr
sc  output  3  raw SC value, debug
instr_cnt  output  16  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): SC=0, IR=0, state=RUN, seq_err=0, instr_cnt=0. Outputs after reset: T=7'b0000001, D=8'b00000001, I=0, B=0, running=1.
- States: RUN, HALT. No other states.
- T is decoded from SC: T[k]=1 iff SC==k and state==RUN. In HALT, T=0.
- SC next value, in priority order:
  - glb_clr: 0
  - halt entry (see below): 0
  - seq_clr: 0
  - SC==6: 0, and seq_err set to 1
  - otherwise: SC+1
  - SC holds while in HALT.
- IR: glb_clr loads 0. Otherwise ir_ld loads bus. IR is updated only when state==RUN. An IR load at T1 is visible on D/I/B from T2 onward.
- D/I/B are purely combinational from IR: D[k]=(IR[14:12]==k), I=IR[15], B=IR[11:0]. They stay valid in HALT.
- Halt entry: state goes RUN→HALT on the next edge when either condition holds:
  - internal HLT: T[3] & D[7] & ~I & B[0]
  - err_halt=1 while RUN
- HALT→RUN on start=1. SC resumes from 0, so T0 is asserted in the cycle after the start edge.
- glb_clr in any state: state=RUN, SC=0, IR=0, seq_err=0, instr_cnt=0.
- Simultaneous events:
  - glb_clr beats everything.
  - Halt beats seq_clr and start.
  - ir_ld together with halt: IR still loads.
  - start while already RUN is ignored.
- seq_err clears only on rst_n or glb_clr.
- Latency: all outputs are registered-state decode, zero combinational paths from inputs to outputs.

Optional Feature:
- Macro: INSTR_COUNT_EN.
- Defined: a 16-bit instr_cnt register increments on every edge where seq_clr=1, state==RUN and glb_clr=0. It wraps 0xFFFF→0x0000, resets to 0 and clears on glb_clr.
- Not defined: instr_cnt is tied to 16'h0000 and no counter flops are built.

Test Plan:
- Reset then free run, no seq_clr → T walks 0x01,0x02,…,0x40, then SC wraps to 0 with seq_err=1 in the cycle after T6.
- bus=16'h7001, ir_ld at T1 → at T2, D=8'h80, I=0, B=12'h001. Asserting T3 stops the machine: running=0, T=0 on the next edge; start pulse → T=0x01 one cycle later.
- bus=16'h2123, ir_ld at T1, seq_clr at T5 → next cycle SC=0 (T=0x01), D=8'h04, I=0, B=12'h123. With INSTR_COUNT_EN, instr_cnt increments by 1.
- err_halt at T2 together with seq_clr → HALT with SC=0. ir_ld during HALT leaves IR unchanged. glb_clr during HALT → RUN, T=0x01, IR=0, seq_err=0.
- With INSTR_COUNT_EN, preload instr_cnt to 0xFFFF via 65535 seq_clr pulses, one more pulse → instr_cnt=0x0000.
- rst_n asserted mid-instruction (SC=4, IR=16'hF020) → immediately SC=0, IR=0, T=0x01, running=1, with no clock edge required.
